// File: rtl/cam_pix_stream_src.sv
// Camera pixel source: buffers 10-bit camera pixels in a small circular FIFO and
// presents them one at a time to the reader through a registered ready/request handshake.
module cam_pix_stream_src #(
    parameter int DATA_W       = 10,
    parameter int ADDR_W       = 4,
    parameter int FRAME_PIXELS = 76800,
    parameter int CNT_W        = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_vsync,
    input  logic              cam_pix_valid,
    input  logic [DATA_W-1:0] cam_pix_data,
    input  logic              vga2_req,
    output logic [DATA_W-1:0] rd2_data,
    output logic              pix_rdy,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic              frame_done,
    output logic [CNT_W-1:0]  pix_count
);

    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(FRAME_PIXELS - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rdy_q, rdy_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              fdone_q, fdone_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;

    logic pop, load, st_rd, bypass, st_wr, drop, mem_we;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        rdy_d    = rdy_q;
        ovf_d    = ovf_q;
        fdone_d  = 1'b0;
        pcnt_d   = pcnt_q;

        // The output register refills whenever it is empty or being consumed;
        // storage has priority over the live camera pixel to preserve order.
        pop    = vga2_req & rdy_q;
        load   = ~rdy_q | pop;
        st_rd  = load & (count_q != '0);
        bypass = load & (count_q == '0) & cam_pix_valid;
        st_wr  = cam_pix_valid & ~bypass & ((count_q != DEPTH_C) | st_rd);
        drop   = cam_pix_valid & ~bypass & (count_q == DEPTH_C) & ~st_rd;
        mem_we = st_wr & ~cam_vsync;

        if (st_rd) begin
            data_d   = mem_q[rd_ptr_q];
            rdy_d    = 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (bypass) begin
            data_d = cam_pix_data;
            rdy_d  = 1'b1;
        end else if (load) begin
            rdy_d = 1'b0;
        end

        if (st_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({st_wr, st_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            if (pcnt_q == LAST_C) begin
                pcnt_d  = '0;
                fdone_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end

        // Frame start realigns the stream; the sticky overflow flag survives it.
        if (cam_vsync) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rdy_d    = 1'b0;
            pcnt_d   = '0;
            fdone_d  = 1'b0;
            ovf_d    = ovf_q;
        end

        level_d = count_d + (ADDR_W + 1)'(rdy_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            rdy_q    <= 1'b0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            fdone_q  <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            rdy_q    <= rdy_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            fdone_q  <= fdone_d;
            pcnt_q   <= pcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we & ~reset) begin
            mem_q[wr_ptr_q] <= cam_pix_data;
        end
    end

    assign rd2_data   = data_q;
    assign pix_rdy    = rdy_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign frame_done = fdone_q;
    assign pix_count  = pcnt_q;

endmodule

// File: tb/tb_cam_pix_stream_src.sv
// Scoreboard bench for cam_pix_stream_src: a queue-based model of the DEPTH+1 pixel
// buffer predicts consumed pixels and post-edge status; monitors compare against the DUT.
module tb_cam_pix_stream_src;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 4;
    localparam int FP     = 4;
    localparam int CNT_W  = 17;
    localparam int CAP    = (2 ** ADDR_W) + 1;

    logic              clk = 1'b0;
    logic              reset, cam_vsync, cam_pix_valid, vga2_req;
    logic [DATA_W-1:0] cam_pix_data;
    logic [DATA_W-1:0] rd2_data;
    logic              pix_rdy, overflow, frame_done;
    logic [ADDR_W:0]   fifo_level;
    logic [CNT_W-1:0]  pix_count;

    cam_pix_stream_src #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_PIXELS(FP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .cam_vsync(cam_vsync),
        .cam_pix_valid(cam_pix_valid), .cam_pix_data(cam_pix_data),
        .vga2_req(vga2_req), .rd2_data(rd2_data), .pix_rdy(pix_rdy),
        .fifo_level(fifo_level), .overflow(overflow), .frame_done(frame_done),
        .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              rdy;
        logic [DATA_W-1:0] data;
        logic [ADDR_W:0]   lvl;
        logic              ovf;
        logic              fd;
        logic [CNT_W-1:0]  cnt;
    } st_t;

    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] exp_q[$];
    st_t               st_q[$];
    logic              m_ovf;
    int                m_cnt;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a bounded pixel queue of DEPTH+1 entries
    task automatic model_step(input logic rst, input logic vs, input logic v,
                              input logic [DATA_W-1:0] d, input logic rq);
        st_t s;
        logic fd = 1'b0;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else if (vs) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (rq && mq.size() > 0) begin
                exp_q.push_back(mq.pop_front());
                if (m_cnt == FP - 1) begin
                    m_cnt = 0;
                    fd    = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            if (v) begin
                if (mq.size() < CAP) mq.push_back(d);
                else                 m_ovf = 1'b1;
            end
        end
        s.rst  = rst;
        s.rdy  = (mq.size() > 0);
        s.data = (mq.size() > 0) ? mq[0] : '0;
        s.lvl  = (ADDR_W + 1)'(mq.size());
        s.ovf  = m_ovf;
        s.fd   = fd;
        s.cnt  = CNT_W'(m_cnt);
        st_q.push_back(s);
    endtask

    task automatic cycle(input logic rst, input logic vs, input logic v,
                         input logic [DATA_W-1:0] d, input logic rq);
        reset         = rst;
        cam_vsync     = vs;
        cam_pix_valid = v;
        cam_pix_data  = d;
        vga2_req      = rq;
        model_step(rst, vs, v, d, rq);
        @(posedge clk);
        #2;
    endtask

    // Post-edge status monitor
    st_t ms;
    always @(posedge clk) begin
        #1;
        if (st_q.size() > 0) begin
            ms = st_q.pop_front();
            chk("pix_rdy", 32'(pix_rdy), 32'(ms.rdy));
            chk("fifo_level", 32'(fifo_level), 32'(ms.lvl));
            chk("overflow", 32'(overflow), 32'(ms.ovf));
            chk("frame_done", 32'(frame_done), 32'(ms.fd));
            chk("pix_count", 32'(pix_count), 32'(ms.cnt));
            if (ms.rst || ms.rdy) chk("rd2_data", 32'(rd2_data), 32'(ms.data));
        end
    end

    // Consumption monitor: a pixel is taken at the coming edge
    always @(negedge clk) begin
        if (reset === 1'b0 && cam_vsync === 1'b0 && vga2_req === 1'b1 && pix_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", rd2_data);
            end else begin
                chk("pixel_order", 32'(rd2_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        m_ovf = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, DATA_W'($urandom_range(0, 1023)), 1);
        cycle(0, 0, 0, '0, 0);

        cycle(0, 0, 1, 10'h2A5, 0);
        cycle(0, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);

        for (int i = 1; i <= 18; i++) cycle(0, 0, 1, DATA_W'(i), 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, 1);

        cycle(1, 0, 0, '0, 0);
        for (int i = 0; i < 64; i++) cycle(0, 0, 1, DATA_W'(10'h100 + i), 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1);

        cycle(0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, DATA_W'(10'h050 + i), 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, DATA_W'(10'h060 + i), 0);
        cycle(0, 1, 1, 10'h3FF, 1);
        cycle(0, 0, 0, '0, 0);

        for (int i = 0; i < 3000; i++) begin
            int mode = (i / 200) % 3;
            logic v  = ($urandom_range(0, 3) != 0);
            logic rq = (mode == 0) ? ($urandom_range(0, 3) == 0) :
                       (mode == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1);
            logic vs = ($urandom_range(0, 199) == 0);
            logic rs = ($urandom_range(0, 999) == 0);
            cycle(rs, vs, v, DATA_W'($urandom_range(0, 1023)), rq);
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, 1);
        cycle(0, 0, 0, '0, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pix_stream_src.md
Name: cam_pix_stream_src

Overview:
- Upstream stage feeding img_cpu_reader's pixel handshake: pix_rdy, rd2_data[9:0] and vga2_req.
- Accepts 10-bit pixels from the camera capture path and buffers them in a small FIFO.
- Presents the head pixel to the reader with a ready/request handshake.
- Tracks pixels consumed per frame and flushes on camera vsync so each frame starts aligned.

Parameters:
- DATA_W, 10, pixel width (must match rd2_data).
- ADDR_W, 4, FIFO storage address width; storage depth DEPTH = 2**ADDR_W = 16.
- FRAME_PIXELS, 76800, pixels per frame (320x240).
- CNT_W, 17, width of the per-frame consumed-pixel counter.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- cam_vsync  input  1  one-cycle pulse at start of camera frame; flushes buffer and counters.
- cam_pix_valid  input  1  cam_pix_data valid this cycle.
- cam_pix_data  input  DATA_W  camera pixel.
- vga2_req  input  1  reader request; consumes the presented pixel when pix_rdy=1.
- rd2_data  output  DATA_W  presented pixel, registered.
- pix_rdy  output  1  rd2_data holds a valid, unconsumed pixel.
- fifo_level  output  ADDR_W+1  storage entries plus pix_rdy (0..DEPTH+1).
- overflow  output  1  sticky: a pixel was dropped because the buffer was full.
- frame_done  output  1  one-cycle pulse when the FRAME_PIXELS-th pixel of the frame is consumed.
- pix_count  output  CNT_W  pixels consumed in current frame.

Behaviour:
- Reset values (synchronous, clk edge with reset=1):
  - rd2_data=0, pix_rdy=0, fifo_level=0, overflow=0, frame_done=0, pix_count=0.
  - FIFO pointers and count cleared.
  - Reset mid-transfer discards all buffered pixels.
- Structure: DEPTH-entry circular storage (wr_ptr, rd_ptr, count) plus a one-entry output register (rd2_data/pix_rdy). Total capacity DEPTH+1.
- Consume: pop = vga2_req & pix_rdy. vga2_req while pix_rdy=0 is ignored with no side effects.
- Output register next state, priority order:
  1. If pix_rdy=0 or pop: load the storage head if count>0; else load the incoming pixel if cam_pix_valid (bypass); else pix_rdy<=0.
  2. Otherwise hold.
- Write path (when not bypassed into the output register):
  - cam_pix_valid writes storage if count<DEPTH, evaluated on start-of-cycle count.
  - A write and a storage read in the same cycle are both performed; count is unchanged.
  - If count==DEPTH and no storage read occurs this cycle: drop the pixel and set overflow=1. overflow clears only on reset.
- Latency: write into an empty block gives pix_rdy=1 the next cycle. Sustained pop every cycle with data available gives one pixel per cycle, with no bubble.
- Ordering: pixels emerge strictly in write order; pointers wrap modulo DEPTH.
- fifo_level is registered and equals count + pix_rdy after the edge.
- Frame counter:
  - Each pop increments pix_count.
  - On the pop that makes the count reach FRAME_PIXELS: frame_done=1 for that one following cycle and pix_count<=0 (wraps).
- cam_vsync (when reset=0): same edge clears storage, pix_rdy, pix_count and frame_done.
  - A cam_pix_valid in the same cycle is dropped and does not set overflow.
  - A vga2_req in the same cycle has no effect.
  - overflow is not cleared.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset behaviour: hold reset 3 cycles with cam_pix_valid=1 and vga2_req=1 -> all outputs 0 throughout and one cycle after release.
- Single-pixel bypass: write 0x2A5 with vga2_req=0 -> next cycle pix_rdy=1, rd2_data=0x2A5, fifo_level=1. Pulse vga2_req -> pix_rdy=0, pix_count=1.
- Fill and overflow: write 0x001..0x012 (18 pixels) with vga2_req=0 -> fifo_level=17 and overflow=1 after the 18th. Draining then yields 0x001..0x011 in order; 0x012 is never seen.
- Back-to-back streaming: write 0x100..0x13F continuously with vga2_req=1 every cycle -> rd2_data increments by one per cycle, no gaps, overflow=0.
- Frame completion and flush (FRAME_PIXELS=4):
  - Consume 4 pixels -> frame_done pulses exactly one cycle and pix_count returns to 0.
  - Then load 5 pixels and assert cam_vsync together with cam_pix_valid -> pix_rdy=0, fifo_level=0, overflow unchanged.
